// File: rtl/alp_pkg.sv
// Shared definitions for the ALP arbiter: datapath widths, FSM states and
// the 3-bit ALP opcode map.
package alp_pkg;

  localparam int ALP_DATA_W = 4;
  localparam int ALP_OP_W   = 3;
  localparam int ALP_NREQ   = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LD0  = 3'd2,
    S_LD1  = 3'd3,
    S_COMP = 3'd4,
    S_WAIT = 3'd5,
    S_RESP = 3'd6
  } alp_state_e;

  typedef enum logic [ALP_OP_W-1:0] {
    ALP_OP_NOP = 3'd0,
    ALP_OP_ADD = 3'd1,
    ALP_OP_SUB = 3'd2,
    ALP_OP_AND = 3'd3,
    ALP_OP_OR  = 3'd4,
    ALP_OP_XOR = 3'd5,
    ALP_OP_SHL = 3'd6,
    ALP_OP_SHR = 3'd7
  } alp_op_e;

  // Requester index to one-hot lane vector.
  function automatic logic [ALP_NREQ-1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alp_rr_arb.sv
// Two-way grant logic. Round-robin by default; ALP_ARB_FIXED_PRIO_EN makes
// requester 0 always win a tie and removes the pointer register.
module alp_rr_arb
  import alp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ALP_NREQ-1:0] req,
  input  logic                adv,
  output logic [ALP_NREQ-1:0] gnt
);

`ifdef ALP_ARB_FIXED_PRIO_EN

  logic unused_sigs;
  assign unused_sigs = &{1'b0, clk, rst_n, adv};

  assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};

`else

  logic ptr_reg;

  // Pointer names the preferred requester; it moves to the loser on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
    end else if (adv && (|req)) begin
      ptr_reg <= gnt[0];
    end
  end

  assign gnt = (&req) ? idx_onehot(ptr_reg) : req;

`endif

endmodule

// File: rtl/alp_arbiter.sv
// Shares one ALP between two requesters: arbitrates, sequences clr/load/comp,
// waits COMP_CYCLES and returns the result. Option: ALP_ARB_FIXED_PRIO_EN.
module alp_arbiter
  import alp_pkg::*;
#(
  parameter int COMP_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ALP_NREQ-1:0]              req_valid,
  output logic [ALP_NREQ-1:0]              req_ready,
  input  logic [ALP_NREQ*ALP_OP_W-1:0]     req_op,
  input  logic [ALP_NREQ*ALP_DATA_W-1:0]   req_a,
  input  logic [ALP_NREQ*ALP_DATA_W-1:0]   req_b,
  output logic [ALP_NREQ-1:0]              rsp_valid,
  input  logic [ALP_NREQ-1:0]              rsp_ready,
  output logic [ALP_DATA_W-1:0]            rsp_out0,
  output logic [ALP_DATA_W-1:0]            rsp_out1,
  output logic                             rsp_err,
  output logic                             busy,
  output logic                             alp_clr,
  output logic                             alp_load,
  output logic                             alp_comp,
  output logic [ALP_OP_W-1:0]              alp_op,
  output logic [ALP_DATA_W-1:0]            alp_data,
  input  logic [ALP_DATA_W-1:0]            alp_out_0,
  input  logic [ALP_DATA_W-1:0]            alp_out_1,
  input  logic                             alp_err
);

  alp_state_e              state_reg, state_next;
  logic                    win_reg;
  logic [ALP_OP_W-1:0]     op_reg;
  logic [ALP_DATA_W-1:0]   a_reg, b_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [ALP_DATA_W-1:0]   out0_reg, out1_reg;
  logic                    err_reg;

  logic [ALP_OP_W-1:0]     op_arr [ALP_NREQ];
  logic [ALP_DATA_W-1:0]   a_arr  [ALP_NREQ];
  logic [ALP_DATA_W-1:0]   b_arr  [ALP_NREQ];
  logic [ALP_NREQ-1:0]     gnt;
  logic                    grant_fire;
  logic                    win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < ALP_NREQ; gi++) begin : g_lane
      assign op_arr[gi]    = req_op[gi*ALP_OP_W +: ALP_OP_W];
      assign a_arr[gi]     = req_a[gi*ALP_DATA_W +: ALP_DATA_W];
      assign b_arr[gi]     = req_b[gi*ALP_DATA_W +: ALP_DATA_W];
      assign req_ready[gi] = grant_fire && gnt[gi];
      assign rsp_valid[gi] = (state_reg == S_RESP) && (win_reg == 1'(gi));
    end
  endgenerate

  assign grant_fire = (state_reg == S_IDLE) && (|req_valid);
  assign win_idx    = gnt[1];

  alp_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .adv   (grant_fire),
    .gnt   (gnt)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_fire) state_next = S_CLR;
      S_CLR:   state_next = S_LD0;
      S_LD0:   state_next = S_LD1;
      S_LD1:   state_next = S_COMP;
      S_COMP:  state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == '0) state_next = S_RESP;
      S_RESP:  if (rsp_ready[win_reg]) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      win_reg   <= 1'b0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      out0_reg  <= '0;
      out1_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_fire) begin
        win_reg <= win_idx;
        op_reg  <= op_arr[win_idx];
        a_reg   <= a_arr[win_idx];
        b_reg   <= b_arr[win_idx];
      end
      // The wait window starts counting from the cycle after the comp strobe.
      if (state_reg == S_COMP) begin
        cnt_reg <= CNT_W'(COMP_CYCLES - 1);
      end else if ((state_reg == S_WAIT) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if ((state_reg == S_WAIT) && (cnt_reg == '0)) begin
        out0_reg <= alp_out_0;
        out1_reg <= alp_out_1;
        err_reg  <= alp_err;
      end
    end
  end

  always_comb begin
    alp_clr  = 1'b0;
    alp_load = 1'b0;
    alp_comp = 1'b0;
    alp_op   = '0;
    alp_data = '0;
    case (state_reg)
      S_CLR: begin
        alp_clr = 1'b1;
        alp_op  = op_reg;
      end
      S_LD0: begin
        alp_load = 1'b1;
        alp_data = a_reg;
        alp_op   = op_reg;
      end
      S_LD1: begin
        alp_load = 1'b1;
        alp_data = b_reg;
        alp_op   = op_reg;
      end
      S_COMP: begin
        alp_comp = 1'b1;
        alp_op   = op_reg;
      end
      S_WAIT:  alp_op = op_reg;
      default: ;
    endcase
  end

  assign busy     = (state_reg != S_IDLE);
  assign rsp_out0 = out0_reg;
  assign rsp_out1 = out1_reg;
  assign rsp_err  = err_reg;

endmodule

// File: tb/tb_alp_arbiter.sv
// Bench for alp_arbiter: cycle-phase model compared every cycle plus directed
// literal checks; a second instance runs with COMP_CYCLES = 1.
module tb_alp_arbiter;

  localparam int C = 8;
`ifdef ALP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] rsp_ready = 2'b11;
  logic [5:0] req_op    = '0;
  logic [7:0] req_a     = '0;
  logic [7:0] req_b     = '0;
  logic [3:0] stub_out0 = '0;
  logic [3:0] stub_out1 = '0;
  logic       stub_err  = 1'b0;

  logic [1:0] req_ready, rsp_valid;
  logic [3:0] rsp_out0, rsp_out1, alp_data;
  logic       rsp_err, busy, alp_clr, alp_load, alp_comp;
  logic [2:0] alp_op;

  alp_arbiter #(.COMP_CYCLES(C), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out0(rsp_out0), .rsp_out1(rsp_out1), .rsp_err(rsp_err), .busy(busy),
    .alp_clr(alp_clr), .alp_load(alp_load), .alp_comp(alp_comp),
    .alp_op(alp_op), .alp_data(alp_data),
    .alp_out_0(stub_out0), .alp_out_1(stub_out1), .alp_err(stub_err)
  );

  // Second instance: shortest compute window.
  logic [1:0] v1_valid = 2'b00;
  logic [1:0] v1_rsp_ready = 2'b11;
  logic [5:0] v1_op = 6'b000_001;
  logic [7:0] v1_a = 8'h01, v1_b = 8'h01;
  logic [3:0] v1_stub = 4'h0;
  logic       v1_stub_err = 1'b0;
  logic [1:0] v1_ready, v1_rsp_valid;
  logic [3:0] v1_out0, v1_out1, v1_data;
  logic       v1_err, v1_busy, v1_clr, v1_load, v1_comp;
  logic [2:0] v1_aop;

  alp_arbiter #(.COMP_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1_valid), .req_ready(v1_ready),
    .req_op(v1_op), .req_a(v1_a), .req_b(v1_b),
    .rsp_valid(v1_rsp_valid), .rsp_ready(v1_rsp_ready),
    .rsp_out0(v1_out0), .rsp_out1(v1_out1), .rsp_err(v1_err), .busy(v1_busy),
    .alp_clr(v1_clr), .alp_load(v1_load), .alp_comp(v1_comp),
    .alp_op(v1_aop), .alp_data(v1_data),
    .alp_out_0(v1_stub), .alp_out_1(v1_stub), .alp_err(v1_stub_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_k counts cycles since the accept cycle (1 = first cycle after accept).
  bit         m_busy = 1'b0;
  int         m_k    = 0;
  bit         m_win  = 1'b0;
  bit         m_ptr  = 1'b0;
  logic [2:0] m_op   = '0;
  logic [3:0] m_a = '0, m_b = '0, m_out0 = '0, m_out1 = '0;
  logic       m_err  = 1'b0;

  function automatic bit pick(input logic [1:0] v, input bit p);
    if (v == 2'b11) return FIXED ? 1'b0 : p;
    return v[1] && !v[0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_ptr  <= 1'b0;
      m_out0 <= '0;
      m_out1 <= '0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_win  <= pick(req_valid, m_ptr);
        m_op   <= pick(req_valid, m_ptr) ? req_op[5:3] : req_op[2:0];
        m_a    <= pick(req_valid, m_ptr) ? req_a[7:4] : req_a[3:0];
        m_b    <= pick(req_valid, m_ptr) ? req_b[7:4] : req_b[3:0];
        m_ptr  <= FIXED ? 1'b0 : !pick(req_valid, m_ptr);
      end
    end else if (m_k >= 5 + C) begin
      if (rsp_ready[m_win]) begin
        m_busy <= 1'b0;
        m_k    <= 0;
      end
    end else begin
      if (m_k == 4 + C) begin
        m_out0 <= stub_out0;
        m_out1 <= stub_out1;
        m_err  <= stub_err;
      end
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {6'd0, req_ready},
            (!m_busy && req_valid != 2'b00) ? (8'd1 << pick(req_valid, m_ptr)) : 8'd0);
      check("busy", {7'd0, busy}, {7'd0, m_busy});
      check("alp_clr", {7'd0, alp_clr}, {7'd0, m_busy && m_k == 1});
      check("alp_load", {7'd0, alp_load}, {7'd0, m_busy && (m_k == 2 || m_k == 3)});
      check("alp_comp", {7'd0, alp_comp}, {7'd0, m_busy && m_k == 4});
      check("alp_data", {4'd0, alp_data},
            (m_busy && m_k == 2) ? {4'd0, m_a} : (m_busy && m_k == 3) ? {4'd0, m_b} : 8'd0);
      check("alp_op", {5'd0, alp_op}, (m_busy && m_k <= 4 + C) ? {5'd0, m_op} : 8'd0);
      check("rsp_valid", {6'd0, rsp_valid}, (m_busy && m_k >= 5 + C) ? (8'd1 << m_win) : 8'd0);
      check("rsp_out0", {4'd0, rsp_out0}, {4'd0, m_out0});
      check("rsp_out1", {4'd0, rsp_out1}, {4'd0, m_out1});
      check("rsp_err", {7'd0, rsp_err}, {7'd0, m_err});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int i, output int n);
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        n = c;
        return;
      end
    end
  endtask

  // Issue one request from requester i and return the accept-to-response latency.
  task automatic do_txn(input int i, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, output int n);
    bit ok;
    tick;
    req_valid[i]        = 1'b1;
    req_op[i*3 +: 3]    = op;
    req_a[i*4 +: 4]     = a;
    req_b[i*4 +: 4]     = b;
    wait_ready(i, ok);
    check("accept_seen", {7'd0, ok}, 8'd1);
    tick;
    req_valid[i] = 1'b0;
    wait_rsp(i, n);
  endtask

  logic [1:0] exp_gnt [3];

  initial begin
    int  n;
    bit  ok;
    logic [1:0] seen;

    if (FIXED) exp_gnt = '{2'b01, 2'b01, 2'b01};
    else       exp_gnt = '{2'b01, 2'b10, 2'b01};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_req_ready", {6'd0, req_ready}, 8'd0);
    check("rst_rsp_valid", {6'd0, rsp_valid}, 8'd0);
    check("rst_rsp_out0", {4'd0, rsp_out0}, 8'd0);
    check("rst_strobes", {5'd0, alp_clr, alp_load, alp_comp}, 8'd0);
    check("rst_alp_op", {5'd0, alp_op}, 8'd0);
    check("rst_alp_data", {4'd0, alp_data}, 8'd0);
    tick;
    rst_n = 1'b1;

    // COMP_CYCLES = 1: response at t+6
    tick;
    v1_valid = 2'b01;
    @(negedge clk);
    check("c1_accept", {6'd0, v1_ready}, 8'h01);
    tick;
    v1_valid = 2'b00;
    n = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (v1_rsp_valid[0]) begin
        n = c;
        break;
      end
    end
    check("c1_latency", 8'(n), 8'd6);

    // Single request: 3 + 2 with stub returning 5
    stub_out0 = 4'h5;
    stub_out1 = 4'h0;
    stub_err  = 1'b0;
    do_txn(0, 3'b001, 4'h3, 4'h2, n);
    check("single_latency", 8'(n), 8'd13);
    check("single_out0", {4'd0, rsp_out0}, 8'h05);
    tick;

    // Simultaneous requests from reset, both held
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req_op    = {3'd2, 3'd1};
    req_a     = 8'h14;
    req_b     = 8'h11;
    req_valid = 2'b11;
    for (int g = 0; g < 3; g++) begin
      seen = 2'b00;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          seen = req_ready;
          break;
        end
      end
      check("tie_grant", {6'd0, seen}, {6'd0, exp_gnt[g]});
      tick;
    end
    req_valid = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("tie_drain", {7'd0, ok}, 8'd1);

    // Response backpressure with req1 waiting
    rsp_ready = 2'b00;
    stub_out0 = 4'h8;
    stub_out1 = 4'hA;
    tick;
    req_valid[0] = 1'b1;
    req_op[2:0]  = 3'd1;
    req_a[3:0]   = 4'h7;
    req_b[3:0]   = 4'h1;
    wait_ready(0, ok);
    check("bp_accept", {7'd0, ok}, 8'd1);
    tick;
    req_valid   = 2'b10;
    req_op[5:3] = 3'd5;
    req_a[7:4]  = 4'hC;
    req_b[7:4]  = 4'h3;
    wait_rsp(0, n);
    check("bp_latency", 8'(n), 8'd13);
    for (int c = 0; c < 10; c++) begin
      tick;
      stub_out0 = 4'h6;
      stub_out1 = 4'h0;
      @(negedge clk);
      check("bp_valid", {6'd0, rsp_valid}, 8'h01);
      check("bp_out0", {4'd0, rsp_out0}, 8'h08);
      check("bp_out1", {4'd0, rsp_out1}, 8'h0A);
      check("bp_busy", {7'd0, busy}, 8'd1);
      check("bp_no_accept", {6'd0, req_ready}, 8'h00);
    end
    tick;
    rsp_ready = 2'b10;
    @(negedge clk);
    check("bp_nonwinner_ignored", {6'd0, rsp_valid}, 8'h01);
    tick;
    rsp_ready = 2'b01;
    wait_ready(1, ok);
    check("bp_req1_accept", {7'd0, ok}, 8'd1);
    tick;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_rsp(1, n);
    check("req1_latency", 8'(n), 8'd13);
    check("req1_out0", {4'd0, rsp_out0}, 8'h06);
    tick;

    // Error capture, then cleared
    stub_err  = 1'b1;
    stub_out0 = 4'hF;
    do_txn(0, 3'd2, 4'h1, 4'h2, n);
    check("err_set", {7'd0, rsp_err}, 8'd1);
    tick;
    stub_err  = 1'b0;
    stub_out0 = 4'h3;
    do_txn(0, 3'd1, 4'h1, 4'h2, n);
    check("err_clear", {7'd0, rsp_err}, 8'd0);
    check("err_clear_out0", {4'd0, rsp_out0}, 8'h03);
    tick;

    // Reset during WAIT
    tick;
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    check("rw_accept", {7'd0, ok}, 8'd1);
    tick;
    req_valid = 2'b00;
    repeat (6) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_busy", {7'd0, busy}, 8'd0);
    check("rw_rsp_valid", {6'd0, rsp_valid}, 8'h00);
    check("rw_alp_op", {5'd0, alp_op}, 8'h00);
    check("rw_out0", {4'd0, rsp_out0}, 8'h00);
    check("rw_strobes", {5'd0, alp_clr, alp_load, alp_comp}, 8'd0);
    stub_out0 = 4'h9;
    do_txn(1, 3'd1, 4'h4, 4'h5, n);
    check("rw_after_latency", 8'(n), 8'd13);
    check("rw_after_out0", {4'd0, rsp_out0}, 8'h09);

    repeat (3) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
